// File: rtl/flap_button_conditioner.sv
// Turns the raw flap pushbutton into clean single-cycle flap strobes:
// 2-flop synchronizer, press/release debounce, optional auto-repeat, press counter.
module flap_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 30000000,
  parameter int REPEAT_CYCLES   = 15000000,
  parameter int REPEAT_EN       = 0,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_raw,
  output logic       flap_pulse,
  output logic       flap_level,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             repeat_phase_q, repeat_phase_d;
  logic             flap_pulse_q, flap_pulse_d;
  logic             flap_level_q, flap_level_d;
  logic [7:0]       press_count_q, press_count_d;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    repeat_phase_d = repeat_phase_q;
    flap_pulse_d   = 1'b0;
    flap_level_d   = flap_level_q;
    press_count_d  = press_count_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          timer_d = ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d        = HELD;
          timer_d        = '0;
          repeat_phase_d = 1'b0;
          flap_pulse_d   = 1'b1;
          flap_level_d   = 1'b1;
          if (press_count_q != 8'hFF) press_count_d = press_count_q + 8'd1;
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          timer_d = ONE;
        end else if (REPEAT_EN != 0) begin
          // First repeat waits the long hold time, later ones the shorter period
          if (timer_q == (repeat_phase_q ? REP_LAST : HOLD_LAST)) begin
            flap_pulse_d   = 1'b1;
            timer_d        = '0;
            repeat_phase_d = 1'b1;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d      = IDLE;
          timer_d      = '0;
          flap_level_d = 1'b0;
        end else begin
          timer_d = timer_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      state_q        <= IDLE;
      timer_q        <= '0;
      repeat_phase_q <= 1'b0;
      flap_pulse_q   <= 1'b0;
      flap_level_q   <= 1'b0;
      press_count_q  <= 8'd0;
    end else begin
      s1_q           <= btn_raw;
      s2_q           <= s1_q;
      state_q        <= state_d;
      timer_q        <= timer_d;
      repeat_phase_q <= repeat_phase_d;
      flap_pulse_q   <= flap_pulse_d;
      flap_level_q   <= flap_level_d;
      press_count_q  <= press_count_d;
    end
  end

  assign flap_pulse  = flap_pulse_q;
  assign flap_level  = flap_level_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_flap_button_conditioner.sv
// Directed bench for flap_button_conditioner: one instance without and one with
// auto-repeat, small debounce/hold/repeat counts so every timing is hand-checkable.
module tb_flap_button_conditioner;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       btn0 = 1'b0, btn1 = 1'b0;
  logic       p0, l0, p1, l1;
  logic [7:0] c0, c1;

  int n_chk = 0;
  int n_err = 0;
  int np;
  int pidx[16];
  int ldrop;
  int tot;

  always #5 clk = ~clk;

  flap_button_conditioner #(.DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20), .REPEAT_CYCLES(10),
                            .REPEAT_EN(0), .CNT_W(8)) dut0 (
    .clk(clk), .clr(clr), .btn_raw(btn0),
    .flap_pulse(p0), .flap_level(l0), .press_count(c0));

  flap_button_conditioner #(.DEBOUNCE_CYCLES(8), .HOLD_CYCLES(20), .REPEAT_CYCLES(10),
                            .REPEAT_EN(1), .CNT_W(8)) dut1 (
    .clk(clk), .clr(clr), .btn_raw(btn1),
    .flap_pulse(p1), .flap_level(l1), .press_count(c1));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Step n edges, recording edge indices (1-based) of pulses on the chosen DUT
  // and whether its level was ever low.
  task automatic watch(input int n, input int sel);
    np = 0;
    ldrop = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (sel != 0 ? p1 : p0) begin
        if (np < 16) pidx[np] = i;
        np++;
      end
      if (!(sel != 0 ? l1 : l0)) ldrop = 1;
    end
  endtask

  task automatic do_reset();
    btn0 = 1'b0;
    btn1 = 1'b0;
    clr  = 1'b1;
    tick(2);
    clr  = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("reset_pulse0", int'(p0), 0);
    chk("reset_level0", int'(l0), 0);
    chk("reset_count0", int'(c0), 0);
    chk("reset_pulse1", int'(p1), 0);
    chk("reset_count1", int'(c1), 0);

    // Clean press, held 40 cycles, then release
    btn0 = 1'b1;
    watch(40, 0);
    chk("clean_npulse", np, 1);
    chk("clean_pulse_at", pidx[0], 10);
    chk("clean_level", int'(l0), 1);
    chk("clean_count", int'(c0), 1);
    btn0 = 1'b0;
    watch(9, 0);
    chk("release_level_before", int'(l0), 1);
    chk("release_npulse", np, 0);
    tick(1);
    chk("release_level_at10", int'(l0), 0);

    // Bounce on press
    do_reset();
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      btn0 = 1'b1; watch(3, 0); tot += np;
      btn0 = 1'b0; watch(2, 0); tot += np;
    end
    chk("bounce_no_early_pulse", tot, 0);
    btn0 = 1'b1;
    watch(30, 0);
    chk("bounce_npulse", np, 1);
    chk("bounce_pulse_at", pidx[0], 10);
    chk("bounce_count", int'(c0), 1);

    // Release bounce while HELD
    btn0 = 1'b0;
    watch(3, 0);
    tot = np;
    btn0 = 1'b1;
    watch(30, 0);
    tot += np;
    chk("relbounce_npulse", tot, 0);
    chk("relbounce_level_drop", ldrop, 0);
    chk("relbounce_level", int'(l0), 1);
    chk("relbounce_count", int'(c0), 1);

    // Auto-repeat: pulses at rel 0,20,30,40,50 (edges 10,30,40,50,60)
    do_reset();
    btn1 = 1'b1;
    watch(65, 1);
    chk("repeat_npulse", np, 5);
    chk("repeat_p0", pidx[0], 10);
    chk("repeat_p1", pidx[1], 30);
    chk("repeat_p2", pidx[2], 40);
    chk("repeat_p3", pidx[3], 50);
    chk("repeat_p4", pidx[4], 60);
    chk("repeat_count", int'(c1), 1);
    btn1 = 1'b0;
    watch(20, 1);
    chk("repeat_release_npulse", np, 0);
    chk("repeat_release_level", int'(l1), 0);
    chk("repeat_count_after", int'(c1), 1);

    // Saturation over 260 presses
    do_reset();
    tot = 0;
    for (int k = 0; k < 260; k++) begin
      btn0 = 1'b1; watch(12, 0); tot += np;
      btn0 = 1'b0; watch(12, 0); tot += np;
      if (k == 253) chk("sat_count_254", int'(c0), 254);
      if (k == 254) chk("sat_count_255", int'(c0), 255);
    end
    chk("sat_pulses", tot, 260);
    chk("sat_count_final", int'(c0), 255);

    // Reset mid-debounce
    do_reset();
    btn0 = 1'b1;
    watch(5, 0);
    chk("midclr_no_pulse_yet", np, 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("midclr_pulse", int'(p0), 0);
    chk("midclr_level", int'(l0), 0);
    chk("midclr_count", int'(c0), 0);
    watch(20, 0);
    chk("midclr_npulse", np, 1);
    chk("midclr_pulse_at", pidx[0], 10);
    chk("midclr_count_after", int'(c0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
